// File: rtl/i2s_tx_framer.sv
// I2S transmit framer: one-entry L/R holding register with valid/ready intake,
// BCLK/LRCK generation and MSB-first serialisation into 32-bit zero-padded slots.
module i2s_tx_framer #(
  parameter int unsigned DATA_WL  = 16,
  parameter int unsigned SLOT_WL  = 32,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DATA_WL-1:0] l_data,
  input  logic [DATA_WL-1:0] r_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               bclk,
  output logic               lrck,
  output logic               sdata,
  output logic               frame_start,
  output logic               underrun
);

  localparam int unsigned BW     = $clog2(2 * SLOT_WL);
  localparam int unsigned DIVW   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [BW-1:0]   B_LAST   = BW'(2 * SLOT_WL - 1);
  localparam logic [BW-1:0]   B_SLOT   = BW'(SLOT_WL);
  localparam logic [BW-1:0]   B_DATA   = BW'(DATA_WL);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e             state_q;
  logic [DIVW-1:0]    div_q;
  logic               bclk_q;
  logic [BW-1:0]      b_q;
  logic               lrck_q;
  logic               sdata_q;
  logic [DATA_WL-1:0] sh_l_q;
  logic [DATA_WL-1:0] sh_r_q;
  logic [DATA_WL-1:0] hold_l_q;
  logic [DATA_WL-1:0] hold_r_q;
  logic               hold_full_q;
  logic               frame_start_q;
  logic               underrun_q;

  logic               div_wrap;
  logic               fall;
  logic               wrap;
  logic               load;
  logic               accept;
  logic [BW-1:0]      b_d;
  logic [BW-1:0]      slot_d;
  logic               lrck_d;
  logic               data_bit;
  logic               sdata_d;

  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    fall     = (state_q == RUN) && div_wrap && bclk_q;
    wrap     = fall && (b_q == B_LAST);
    load     = ((state_q == IDLE) && en) || (wrap && en);
    accept   = s_valid && !hold_full_q;
    b_d      = (b_q == B_LAST) ? '0 : b_q + 1'b1;
    lrck_d   = (b_d >= B_SLOT);
    slot_d   = lrck_d ? b_d - B_SLOT : b_d;
    data_bit = (slot_d != '0) && (slot_d <= B_DATA);
    sdata_d  = 1'b0;
    if (data_bit) begin
      sdata_d = lrck_d ? sh_r_q[DATA_WL-1] : sh_l_q[DATA_WL-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bclk_q        <= 1'b0;
      b_q           <= '0;
      lrck_q        <= 1'b0;
      sdata_q       <= 1'b0;
      sh_l_q        <= '0;
      sh_r_q        <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      frame_start_q <= load;
      underrun_q    <= load && !hold_full_q;

      // Intake only happens while empty, so a load in the same cycle never drops it.
      if (accept) begin
        hold_l_q    <= l_data;
        hold_r_q    <= r_data;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          div_q   <= '0;
          bclk_q  <= 1'b0;
          b_q     <= '0;
          lrck_q  <= 1'b0;
          sdata_q <= 1'b0;
          if (en) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          div_q <= div_wrap ? '0 : div_q + 1'b1;
          if (div_wrap) begin
            bclk_q <= ~bclk_q;
          end
          // The wrap edge naturally lands on b=0/lrck=0/sdata=0, which doubles as the IDLE values.
          if (fall) begin
            b_q     <= b_d;
            lrck_q  <= lrck_d;
            sdata_q <= sdata_d;
            if (data_bit) begin
              if (lrck_d) begin
                sh_r_q <= sh_r_q << 1;
              end else begin
                sh_l_q <= sh_l_q << 1;
              end
            end
          end
          if (wrap && !en) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load) begin
        sh_l_q <= hold_full_q ? hold_l_q : '0;
        sh_r_q <= hold_full_q ? hold_r_q : '0;
      end
    end
  end

  assign s_ready     = ~hold_full_q;
  assign bclk        = bclk_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_framer.sv
// Bench for i2s_tx_framer: frame-time arithmetic model checked every clock,
// plus directed scenarios with literal expected serial words.
module tb_i2s_tx_framer;

  localparam int DW    = 16;
  localparam int SLOT  = 32;
  localparam int BD    = 4;
  localparam int FRAME = 2 * SLOT * 2 * BD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] l_data = '0;
  logic [DW-1:0] r_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          bclk;
  logic          lrck;
  logic          sdata;
  logic          frame_start;
  logic          underrun;

  i2s_tx_framer #(
    .DATA_WL (DW),
    .SLOT_WL (SLOT),
    .BCLK_DIV(BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .l_data     (l_data),
    .r_data     (r_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .bclk       (bclk),
    .lrck       (lrck),
    .sdata      (sdata),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Model: time since the last frame load determines every output.
  bit            m_run;
  int            m_t;
  bit            m_hold_full;
  logic [DW-1:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;
  bit            m_fs, m_ur;

  always @(posedge clk or negedge rst) begin
    bit ld, acc;
    if (!rst) begin
      m_run = 0; m_t = 0; m_hold_full = 0; m_fs = 0; m_ur = 0;
      m_cur_l = '0; m_cur_r = '0; m_hold_l = '0; m_hold_r = '0;
    end else begin
      acc = s_valid && !m_hold_full;
      ld  = 0;
      if (!m_run) begin
        if (en) ld = 1;
      end else if (m_t == FRAME - 1) begin
        if (en) ld = 1;
        else m_run = 0;
        m_t = 0;
      end else begin
        m_t++;
      end
      m_fs = ld;
      m_ur = ld && !m_hold_full;
      if (ld) begin
        m_run   = 1;
        m_t     = 0;
        m_cur_l = m_hold_full ? m_hold_l : '0;
        m_cur_r = m_hold_full ? m_hold_r : '0;
      end
      if (acc) begin
        m_hold_l = l_data; m_hold_r = r_data; m_hold_full = 1;
      end else if (ld) begin
        m_hold_full = 0;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Serial capture (updated by the monitor)
  logic [63:0] word, lw, prev_word, prev_lw;
  int          nbits, prev_nbits, fs_n, cyc, fs_cyc_last, fs_cyc_prev;
  logic        prev_bclk, last_fs_ur;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input int target, input int limit, output bit got);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (fs_n >= target) break;
    end
    #1;
    got = (fs_n >= target);
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    l_data = l; r_data = r; s_valid = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    word = '0; lw = '0; prev_word = '0; prev_lw = '0;
    nbits = 0; prev_nbits = 0; fs_n = 0; cyc = 0;
    fs_cyc_last = 0; fs_cyc_prev = 0; prev_bclk = 0; last_fs_ur = 0;

    fork
      forever begin
        int b, s;
        logic [DW-1:0] ch;
        logic e_bclk, e_lrck, e_sd;
        @(negedge clk);
        cyc++;
        b      = m_t / (2 * BD);
        s      = b % SLOT;
        ch     = (b >= SLOT) ? m_cur_r : m_cur_l;
        e_bclk = m_run && (((m_t / BD) % 2) == 1);
        e_lrck = m_run && (b >= SLOT);
        e_sd   = m_run && (s >= 1) && (s <= DW) && ch[DW - s];
        chk("bclk", bclk, e_bclk);
        chk("lrck", lrck, e_lrck);
        chk("sdata", sdata, e_sd);
        chk("s_ready", s_ready, !m_hold_full);
        chk("frame_start", frame_start, m_fs);
        chk("underrun", underrun, m_ur);
        if (!rst) begin
          word = '0; lw = '0; nbits = 0; prev_bclk = 0;
        end else begin
          if (bclk && !prev_bclk) begin
            word = {word[62:0], sdata};
            lw   = {lw[62:0], lrck};
            nbits++;
          end
          prev_bclk = bclk;
          if (frame_start) begin
            prev_word = word; prev_lw = lw; prev_nbits = nbits;
            word = '0; lw = '0; nbits = 0;
            fs_n++;
            last_fs_ur  = underrun;
            fs_cyc_prev = fs_cyc_last;
            fs_cyc_last = cyc;
          end
        end
      end
    join_none

    // Reset values, async
    #2 rst = 1'b0;
    #1;
    chk("rst_bclk", bclk, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_ur", underrun, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single frame A5F0/0001
    push(16'hA5F0, 16'h0001);
    tick();
    s_valid = 1'b0;
    chk("t2_s_ready_low", s_ready, 0);
    en = 1'b1;
    tick();
    chk("t2_fs", frame_start, 1);
    chk("t2_ur", underrun, 0);
    wait_fs(2, FRAME + 50, got);
    chk("t2_fs2_seen", got, 1);
    chk("t2_period", fs_cyc_last - fs_cyc_prev, FRAME);
    chk("t2_bits", prev_word, 64'h52F80000_00008000);
    chk("t2_lrck", prev_lw, 64'h00000000_FFFFFFFF);
    chk("t2_nbits", prev_nbits, 64);
    chk("t3_ur", last_fs_ur, 1);

    // Backpressure: A accepted, B held until after A's load
    push(16'h1234, 16'h5678);
    tick();
    chk("t4_a_taken", s_ready, 0);
    push(16'h9ABC, 16'hDEF0);
    wait_fs(3, FRAME + 50, got);
    chk("t4_fs3_seen", got, 1);
    chk("t3_zero_bits", prev_word, 64'h0);
    chk("t4_a_load_ur", last_fs_ur, 0);
    chk("t4_b_taken", s_ready, 0);
    s_valid = 1'b0;
    wait_fs(4, FRAME + 50, got);
    chk("t4_fs4_seen", got, 1);
    chk("t4_a_bits", prev_word, 64'h091A0000_2B3C0000);
    chk("t4_b_load_ur", last_fs_ur, 0);
    wait_fs(5, FRAME + 50, got);
    chk("t4_fs5_seen", got, 1);
    chk("t4_b_bits", prev_word, 64'h4D5E0000_6F780000);
    chk("t4_empty_ur", last_fs_ur, 1);

    // Enable drop at b=10, sample C retained
    push(16'h0F0F, 16'hF0F0);
    tick();
    s_valid = 1'b0;
    repeat (78) tick();
    en = 1'b0;
    wait_fs(6, 700, got);
    chk("t5_no_fs", got, 0);
    chk("t5_nbits", nbits, 64);
    chk("t5_bits", word, 64'h0);
    chk("t5_idle_bclk", bclk, 0);
    chk("t5_idle_lrck", lrck, 0);
    chk("t5_c_held", s_ready, 0);
    en = 1'b1;
    tick();
    chk("t5_restart_fs", frame_start, 1);
    chk("t5_restart_ur", underrun, 0);
    wait_fs(7, FRAME + 50, got);
    chk("t5_fs7_seen", got, 1);
    chk("t5_c_bits", prev_word, 64'h07878000_78780000);

    // Simultaneous: push lands exactly on the load edge with holding empty
    repeat (FRAME - 2) tick();
    push(16'hCAFE, 16'hBEEF);
    tick();
    s_valid = 1'b0;
    chk("t6_fs", frame_start, 1);
    chk("t6_ur", underrun, 1);
    chk("t6_d_taken", s_ready, 0);
    wait_fs(9, FRAME + 50, got);
    chk("t6_fs9_seen", got, 1);
    chk("t6_zero_bits", prev_word, 64'h0);
    chk("t6_d_load_ur", last_fs_ur, 0);
    wait_fs(10, FRAME + 50, got);
    chk("t6_fs10_seen", got, 1);
    chk("t6_d_bits", prev_word, 64'h657F0000_5F778000);

    // Mid-frame reset at b=20 with bclk high and holding full
    push(16'h1111, 16'h2222);
    tick();
    s_valid = 1'b0;
    repeat (162) tick();
    chk("t1_pre_bclk", bclk, 1);
    chk("t1_pre_ready", s_ready, 0);
    #3 rst = 1'b0;
    #1;
    chk("t1_bclk", bclk, 0);
    chk("t1_lrck", lrck, 0);
    chk("t1_sdata", sdata, 0);
    chk("t1_s_ready", s_ready, 1);
    chk("t1_fs", frame_start, 0);
    chk("t1_ur", underrun, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
